// File: rtl/p2s_lanes.sv
// Parallel-to-serial lane converter: N-bit words out as N/W beats of W bits, LSB- or MSB-lane first.
// First beat appears one cycle after accept; the one-word hold buffer gives gapless streaming, and ser_ready stalls freeze the beat.
module p2s_lanes #(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         par_valid,
  input  logic [N-1:0] par_data,
  output logic         par_ready,
  output logic         ser_valid,
  output logic [W-1:0] ser_data,
  output logic         ser_last,
  input  logic         ser_ready,
  output logic         busy
);

  localparam int B  = (W > 0) ? N / W : 1;
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  generate
    if (N < 1 || W < 1 || (N % W) != 0) begin : g_bad_params
      $error("p2s_lanes: N must be >= 1 and a multiple of W");
    end
  endgenerate

  // State is exactly the pair (sr_full, hr_full).
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    ACTIVE = 2'b10,
    FULL   = 2'b11
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  sr, sr_n, sr_shift;
  logic [N-1:0]  hr, hr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sr_full, hr_full;
  logic          acc, fire, done;

  assign sr_full = (state != EMPTY);
  assign hr_full = (state == FULL);

  assign par_ready = !hr_full;
  assign ser_valid = sr_full;
  assign busy      = sr_full || hr_full;
  assign ser_last  = sr_full && (cnt == CW'(B - 1));

  assign acc  = par_valid && par_ready;
  assign fire = ser_valid && ser_ready;
  assign done = fire && ser_last;

  generate
    if (B == 1) begin : g_single_beat
      assign sr_shift = '0;
    end else if (MSB_FIRST) begin : g_shift_left
      assign sr_shift = {sr[N-W-1:0], {W{1'b0}}};
    end else begin : g_shift_right
      assign sr_shift = {{W{1'b0}}, sr[N-1:W]};
    end

    if (MSB_FIRST) begin : g_out_msb
      assign ser_data = sr[N-1 -: W];
    end else begin : g_out_lsb
      assign ser_data = sr[W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= EMPTY;
      sr    <= '0;
      hr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      hr    <= hr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    hr_n    = hr;
    cnt_n   = cnt;
    case (state)
      EMPTY: begin
        if (acc) begin
          sr_n    = par_data;
          cnt_n   = '0;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (done) begin
          // A word offered on the final beat goes straight into the shifter.
          cnt_n = '0;
          if (acc) begin
            sr_n = par_data;
          end else begin
            sr_n    = sr_shift;
            state_n = EMPTY;
          end
        end else begin
          if (fire) begin
            sr_n  = sr_shift;
            cnt_n = cnt + CW'(1);
          end
          if (acc) begin
            hr_n    = par_data;
            state_n = FULL;
          end
        end
      end
      FULL: begin
        if (done) begin
          sr_n    = hr;
          cnt_n   = '0;
          state_n = ACTIVE;
        end else if (fire) begin
          sr_n  = sr_shift;
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rstn)
    (ser_valid && !ser_ready) |=> (ser_valid && $stable(ser_data) && $stable(ser_last)));

endmodule

// File: tb/tb_p2s_lanes.sv
// Bench for p2s_lanes: directed vector table, hand sequences for B==1 and reset, then random traffic against a word-queue model.
module tb_p2s_lanes;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       pv = 1'b0, rdy = 1'b0;
  logic [7:0] pd = 8'h00;
  logic       l_pr, l_sv, l_last, l_busy;
  logic [1:0] l_sd;
  logic       m_pr, m_sv, m_last, m_busy;
  logic [1:0] m_sd;
  logic       bpv = 1'b0, brdy = 1'b0;
  logic [3:0] bpd = 4'h0;
  logic       b_pr, b_sv, b_last, b_busy;
  logic [3:0] b_sd;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  p2s_lanes #(.N(8), .W(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .par_valid(pv), .par_data(pd), .par_ready(l_pr),
    .ser_valid(l_sv), .ser_data(l_sd), .ser_last(l_last), .ser_ready(rdy), .busy(l_busy));

  p2s_lanes #(.N(8), .W(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rstn(rstn), .par_valid(pv), .par_data(pd), .par_ready(m_pr),
    .ser_valid(m_sv), .ser_data(m_sd), .ser_last(m_last), .ser_ready(rdy), .busy(m_busy));

  p2s_lanes #(.N(4), .W(4), .MSB_FIRST(1'b0)) u_b1 (
    .clk(clk), .rstn(rstn), .par_valid(bpv), .par_data(bpd), .par_ready(b_pr),
    .ser_valid(b_sv), .ser_data(b_sd), .ser_last(b_last), .ser_ready(brdy), .busy(b_busy));

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       rdy;
    logic       sv;
    logic [1:0] dl;
    logic [1:0] dm;
    logic       last;
    logic       pr;
    logic       busy;
  } vec_t;

  vec_t tab[23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check8(input string tag, input logic sv, input logic [1:0] dl, input logic [1:0] dm,
                        input logic last, input logic pr, input logic busy);
    chk({tag, " lsb.valid"}, 32'(l_sv), 32'(sv));
    chk({tag, " lsb.last"}, 32'(l_last), 32'(last));
    chk({tag, " lsb.ready"}, 32'(l_pr), 32'(pr));
    chk({tag, " lsb.busy"}, 32'(l_busy), 32'(busy));
    chk({tag, " msb.valid"}, 32'(m_sv), 32'(sv));
    chk({tag, " msb.last"}, 32'(m_last), 32'(last));
    chk({tag, " msb.ready"}, 32'(m_pr), 32'(pr));
    chk({tag, " msb.busy"}, 32'(m_busy), 32'(busy));
    if (sv) begin
      chk({tag, " lsb.data"}, 32'(l_sd), 32'(dl));
      chk({tag, " msb.data"}, 32'(m_sd), 32'(dm));
    end
  endtask

  task automatic check4(input string tag, input logic sv, input logic [3:0] d,
                        input logic last, input logic pr, input logic busy);
    chk({tag, " b1.valid"}, 32'(b_sv), 32'(sv));
    chk({tag, " b1.last"}, 32'(b_last), 32'(last));
    chk({tag, " b1.ready"}, 32'(b_pr), 32'(pr));
    chk({tag, " b1.busy"}, 32'(b_busy), 32'(busy));
    if (sv) chk({tag, " b1.data"}, 32'(b_sd), 32'(d));
  endtask

  // Lane i of an 8-bit word, counted in transmission order.
  function automatic logic [1:0] lane8(input logic [7:0] w, input int i, input bit msb);
    int sh;
    sh = msb ? (6 - 2 * i) : (2 * i);
    return 2'((w >> sh) & 8'h03);
  endfunction

  initial begin
    logic [7:0] q8[$];
    logic [3:0] q4[$];
    int         b8;
    bit         fire8, acc8, fire4, acc4;

    // Each row: outputs expected now, then inputs applied for the next edge.
    tab[0]  = '{1'b1, 8'hB4, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    tab[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1};
    tab[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1};
    tab[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b1};
    tab[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1};
    tab[5]  = '{1'b1, 8'hB4, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    tab[6]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1};
    tab[7]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1};
    tab[8]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1};
    tab[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1};
    tab[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    tab[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1'b1};
    tab[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1'b1};
    tab[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
    tab[14] = '{1'b1, 8'hB4, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    tab[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1};
    tab[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1};
    tab[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1};
    tab[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1};
    tab[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1};
    tab[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b1};
    tab[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1};
    tab[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};

    #2 rstn = 1'b0;
    step();
    step();
    check8("reset", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("reset lsb.data", 32'(l_sd), 32'd0);
    chk("reset msb.data", 32'(m_sd), 32'd0);
    check4("reset", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    rstn = 1'b1;
    step();

    for (int i = 0; i < 23; i++) begin
      check8($sformatf("row%0d", i), tab[i].sv, tab[i].dl, tab[i].dm, tab[i].last, tab[i].pr, tab[i].busy);
      pv  = tab[i].pv;
      pd  = tab[i].pd;
      rdy = tab[i].rdy;
      step();
    end

    // B==1: streaming, then hold-buffer fill under backpressure.
    bpv = 1'b1; bpd = 4'hA; brdy = 1'b1;
    step(); check4("b1 w0", 1'b1, 4'hA, 1'b1, 1'b1, 1'b1); bpd = 4'h5;
    step(); check4("b1 w1", 1'b1, 4'h5, 1'b1, 1'b1, 1'b1); bpd = 4'hF;
    step(); check4("b1 w2", 1'b1, 4'hF, 1'b1, 1'b1, 1'b1); bpv = 1'b0;
    step(); check4("b1 idle", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    bpv = 1'b1; bpd = 4'h1; brdy = 1'b0;
    step(); check4("b1 stall0", 1'b1, 4'h1, 1'b1, 1'b1, 1'b1); bpd = 4'h2;
    step(); check4("b1 stall1", 1'b1, 4'h1, 1'b1, 1'b0, 1'b1); bpd = 4'h3;
    step(); check4("b1 stall2", 1'b1, 4'h1, 1'b1, 1'b0, 1'b1); bpv = 1'b0; brdy = 1'b1;
    step(); check4("b1 drain0", 1'b1, 4'h2, 1'b1, 1'b1, 1'b1);
    step(); check4("b1 drain1", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Reset while the hold buffer is full, during the third beat.
    pv = 1'b1; pd = 8'hB4; rdy = 1'b1;
    step(); check8("mid b0", 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1); pd = 8'h3C;
    step(); check8("mid b1", 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1); pv = 1'b0;
    step(); check8("mid b2", 1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1);
    rstn = 1'b0;
    #1 check8("mid async", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    step();
    rstn = 1'b1;
    step(); check8("post idle", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    pv = 1'b1; pd = 8'h01;
    step(); check8("post b0", 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1); pv = 1'b0;
    step(); check8("post b1", 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    step(); check8("post b2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    step(); check8("post b3", 1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1);
    step(); check8("post idle2", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

    // Random traffic: the model holds in-flight words in order plus the beat index of the head word.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    b8 = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      string t;
      t = $sformatf("rnd%0d", cyc);
      if (q8.size() > 0)
        check8(t, 1'b1, lane8(q8[0], b8, 1'b0), lane8(q8[0], b8, 1'b1), b8 == 3, q8.size() < 2, 1'b1);
      else
        check8(t, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      if (q4.size() > 0)
        check4(t, 1'b1, q4[0], 1'b1, q4.size() < 2, 1'b1);
      else
        check4(t, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

      pv   = ($urandom_range(0, 3) != 0);
      pd   = 8'($urandom);
      rdy  = (cyc % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bpv  = ($urandom_range(0, 2) != 0);
      bpd  = 4'($urandom);
      brdy = ($urandom_range(0, 2) != 0);

      fire8 = (q8.size() > 0) && rdy;
      acc8  = pv && (q8.size() < 2);
      fire4 = (q4.size() > 0) && brdy;
      acc4  = bpv && (q4.size() < 2);
      if (fire8) begin
        b8++;
        if (b8 == 4) begin
          void'(q8.pop_front());
          b8 = 0;
        end
      end
      if (acc8) q8.push_back(pd);
      if (fire4) void'(q4.pop_front());
      if (acc4) q4.push_back(bpd);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/p2s_lanes.md
Name: p2s_lanes

Overview:
- Parametrised parallel-to-serial converter. Accepts N-bit words on a valid/ready parallel port and emits them as N/W beats of W bits on a valid/ready serial port.
- Bit order is selectable: LSB-first or MSB-first.
- Has a one-word holding buffer, so the next word is accepted while the current one is still shifting. Back-to-back words stream with zero idle beats.
- Sits between the keypad/code-word datapath and the serial link toward the lock controller.

Parameters:
- N, 8, parallel word width; N >= 1.
- W, 1, serial lane width; N % W == 0 is required, otherwise elaboration $error.
- MSB_FIRST, 0, 0 = least-significant lane sent first; 1 = most-significant lane sent first.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- par_valid  input  1  parallel word offered.
- par_data  input  N  parallel word.
- par_ready  output  1  hold buffer empty; word accepted on par_valid && par_ready at a clk edge.
- ser_valid  output  1  shifter holds a beat.
- ser_data  output  W  current beat.
- ser_last  output  1  current beat is the final beat of its word.
- ser_ready  input  1  downstream accepts; beat consumed on ser_valid && ser_ready.
- busy  output  1  shifter or hold buffer occupied.

Behaviour:
- B = N/W beats per word. Beat counter width is max(1, $clog2(B)).
- Storage:
  - Shift register SR (N bits), flag sr_full, beat counter cnt.
  - Hold register HR (N bits), flag hr_full.
- Outputs, all registered or derived from registers:
  - par_ready = !hr_full.
  - ser_valid = sr_full.
  - busy = sr_full || hr_full.
  - ser_last = sr_full && (cnt == B-1).
  - ser_data = SR[W-1:0] if MSB_FIRST=0, else SR[N-1:N-W].
- Reset (async, rstn=0):
  - sr_full=0, hr_full=0, cnt=0, SR=0, HR=0.
  - Therefore ser_valid=0, ser_last=0, ser_data=0, busy=0, par_ready=1.
- Definitions:
  - acc = par_valid && par_ready.
  - fire = ser_valid && ser_ready.
  - done = fire && ser_last.
- States, encoded by (sr_full, hr_full):
  - EMPTY (0,0):
    - acc -> load SR=par_data, cnt=0 -> ACTIVE.
    - Otherwise stay.
  - ACTIVE (1,0):
    - fire && !done: shift SR by W (right if LSB-first, left if MSB-first, zero fill); cnt++.
    - done && acc: SR=par_data, cnt=0; stay ACTIVE. This is the zero-bubble path; the word bypasses HR.
    - done && !acc -> EMPTY.
    - !done && acc: HR=par_data -> FULL.
  - FULL (1,1):
    - par_ready=0.
    - fire && !done: shift as above.
    - done: SR=HR, cnt=0, hr_full=0 -> ACTIVE.
- Latency: a word accepted at edge k presents its first beat on ser_data in the cycle after edge k.
- Stalls: while ser_valid && !ser_ready, ser_data, ser_last and cnt hold stable.
- Throughput: with par_valid and ser_ready held high, ser_valid stays high continuously and ser_last pulses every B beats.
- Degenerate case B==1 (W==N):
  - Every beat has ser_last=1.
  - Acts as a 2-deep pipeline buffer with full throughput.
- par_data is sampled only on acc; changes while par_ready=0 have no effect.
- Words are never dropped or reordered, and beats are never duplicated.
- Reset mid-word: the in-flight word and any held word are discarded immediately; outputs return to reset values asynchronously.

Test Plan:
- Single word, LSB-first. N=8, W=2, MSB_FIRST=0, ser_ready=1; send 8'hB4.
  - Required: beats 2'b00, 2'b01, 2'b11, 2'b10 on 4 consecutive cycles starting 1 cycle after accept.
  - ser_last on the 4th beat only; busy drops the cycle after.
- MSB-first. Same stimulus with MSB_FIRST=1.
  - Required: beats 2'b10, 2'b11, 2'b01, 2'b00.
- Back-to-back. N=8, W=2; offer 8'hB4 then 8'h3C with par_valid held, ser_ready=1.
  - Required: 8 contiguous beats 00,01,11,10,00,11,11,00 with no gap.
  - ser_last on beats 4 and 8.
  - par_ready=0 while the shifter and HR are both full.
- Backpressure. Drop ser_ready for 3 cycles after beat 2 of 8'hB4.
  - Required: ser_data stays 2'b01 and ser_valid stays 1 during the stall.
  - Remaining beats 11,10 then follow; no loss or duplication.
- B==1 streaming. N=W=4; stream 4'hA, 4'h5, 4'hF with ser_ready=1.
  - Required: one beat per cycle, each with ser_last=1.
  - With ser_ready=0, par_ready drops after 2 accepted words.
- Reset mid-operation. Assert rstn=0 during beat 3 of a word while HR is full.
  - Required: ser_valid=0, busy=0, par_ready=1 immediately.
  - After release, the next word 8'h01 emits 01,00,00,00 with no stale beats.
